// File: rtl/muxn_pipe.sv
// muxn_pipe: pipelined N-way multiplexer. Each stage registers one 2:1 level of the select tree, with valid/ready flow control.
// Optional feature macro MUXN_PIPE_ERR_EN: out-of-range selects give zero data and out_err; without it the select clamps to N-1.
module muxn_pipe #(
    parameter  int N     = 5,
    parameter  int WIDTH = 32,
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1,
    localparam int LAT   = SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data [N-1:0],
    input  logic [SEL_W-1:0] in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef MUXN_PIPE_ERR_EN
    ,
    output logic             out_err
`endif
);

    // Index 0 is the input side; index k+1 is the registered output of stage k.
    logic [LAT:0]       stage_valid;
    logic [SEL_W-1:0]   stage_sel  [LAT+1];
    logic [WIDTH-1:0]   stage_data [LAT+1][N];
    logic [LAT-1:0]     load;
    logic               sel_oor;

    assign sel_oor = (N > 1) && (int'(in_sel) >= N);

    assign stage_valid[0] = in_valid;

`ifdef MUXN_PIPE_ERR_EN
    logic [LAT:0] stage_err;
    assign stage_err[0] = sel_oor;
    assign stage_sel[0] = in_sel;
`else
    assign stage_sel[0] = sel_oor ? SEL_W'(N - 1) : in_sel;
`endif

    for (genvar gi = 0; gi < N; gi++) begin : g_in
`ifdef MUXN_PIPE_ERR_EN
        // Zeroing every leaf makes the tree result zero whatever select bits follow.
        assign stage_data[0][gi] = sel_oor ? '0 : in_data[gi];
`else
        assign stage_data[0][gi] = in_data[gi];
`endif
    end

    // Ready ripples combinationally from out_ready back through the stage valids.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        load = '0;
        for (int k = LAT - 1; k >= 0; k--) begin
            load[k] = !stage_valid[k+1] || nxt;
            nxt     = load[k];
        end
    end

    for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
        localparam int CNT_IN = (N + (1 << gi) - 1) >> gi;
        localparam int CNT    = (CNT_IN + 1) / 2;

        logic               valid_reg;
        logic [SEL_W-1:0]   sel_reg;
        logic [WIDTH-1:0]   data_reg  [CNT];
        logic [WIDTH-1:0]   data_next [CNT];

        for (genvar gj = 0; gj < CNT; gj++) begin : g_mux
            if (2 * gj + 1 < CNT_IN) begin : g_pair
                assign data_next[gj] = stage_sel[gi][gi] ? stage_data[gi][2*gj+1]
                                                         : stage_data[gi][2*gj];
            end else begin : g_pass
                assign data_next[gj] = stage_data[gi][2*gj];
            end
        end

        // Data only moves with a valid token, so a bubble never disturbs the held result.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_reg <= 1'b0;
                sel_reg   <= '0;
                for (int j = 0; j < CNT; j++) begin
                    data_reg[j] <= '0;
                end
            end else if (load[gi]) begin
                valid_reg <= stage_valid[gi];
                if (stage_valid[gi]) begin
                    sel_reg  <= stage_sel[gi];
                    data_reg <= data_next;
                end
            end
        end

`ifdef MUXN_PIPE_ERR_EN
        logic err_reg;
        always_ff @(posedge clk) begin
            if (rst) begin
                err_reg <= 1'b0;
            end else if (load[gi] && stage_valid[gi]) begin
                err_reg <= stage_err[gi];
            end
        end
        assign stage_err[gi+1] = err_reg;
`endif

        assign stage_valid[gi+1] = valid_reg;
        assign stage_sel[gi+1]   = sel_reg;
        for (genvar gj = 0; gj < N; gj++) begin : g_out
            if (gj < CNT) begin : g_used
                assign stage_data[gi+1][gj] = data_reg[gj];
            end else begin : g_unused
                assign stage_data[gi+1][gj] = '0;
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = stage_valid[LAT];
    assign out_data  = stage_data[LAT][0];
`ifdef MUXN_PIPE_ERR_EN
    assign out_err   = stage_err[LAT];
`endif

endmodule

// File: doc/muxn_pipe.md
# muxn_pipe

Parametrised, pipelined N-way multiplexer with valid/ready flow control. It replaces the purely combinational muxn tree wherever a wide fan-in select sits on a timing-critical path. It registers one 2:1 tree level per pipeline stage, sustains one transfer per cycle, and stalls cleanly under downstream backpressure.

## Interface
Parameters:
- N, default 5: number of data inputs, N ≥ 1.
- WIDTH, default 32: data width in bits, WIDTH ≥ 1.
- SEL_W, derived as max(1, clog2(N)): select width. Not overridable.
- LAT, derived as max(1, clog2(N)): pipeline depth in cycles. Not overridable.

Ports:
- clk, input, 1: the block's single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous, active-high.
- in_valid, input, 1: in_data and in_sel carry a transfer.
- in_ready, output, 1: block accepts a transfer this cycle.
- in_data, input, WIDTH × N: unpacked array, `[WIDTH-1:0] in_data [N-1:0]`.
- in_sel, input, SEL_W: index of the input to forward.
- out_valid, output, 1: out_data holds a result.
- out_ready, input, 1: downstream accepts the result.
- out_data, output, WIDTH: the selected data.
- out_err, output, 1: result came from an out-of-range select. Present only when MUXN_PIPE_ERR_EN is defined.

## Operation
- **Handshake.** A transfer occurs on a cycle where valid and ready are both high, on each side independently.
- **Stages.** There are LAT stages, S0 to S(LAT-1).
  - Stage k holds a valid bit, ceil(N/2^(k+1)) partial results of WIDTH bits, and the select bits above bit k. The error bit is also held when enabled.
  - S0 loads level-0 muxing of in_data, using in_sel[0].
  - Stage k loads level-k muxing of stage k-1, using its sel bit k.
- **Odd counts.** An odd element at a level passes through unmuxed, exactly as in the combinational tree.
- **Degenerate N.** For N=1 there is a single register stage: out_data = in_data[0] and in_sel is ignored. For N=2, LAT = 1.
- **Advance rule.** Stage k loads when its own valid is 0, or when the next stage loads. The last stage's "next loads" condition is out_ready.
  - in_ready = S0 may load.
  - in_ready is combinational from out_ready through the stage valids. No register breaks this path.
- **Stall.** A stage that does not load holds its data, select bits and valid unchanged.
- **Bubbles.** A stage that loads from an invalid predecessor (or from in_valid=0 at S0) clears its valid. Data registers in a loading stage may take any value when the loaded valid is 0; out_data must not change while out_valid=0 and out_ready=0.
- **Out-of-range select.** An in_sel ≥ N is out of range. Behaviour depends on MUXN_PIPE_ERR_EN; see Configuration.
- **Ordering.** Results leave in acceptance order. Nothing is dropped or duplicated.

## Timing
- **Reset.** rst clears every stage valid, data register and error bit. After reset: out_valid=0, out_data=0, out_err=0, and in_ready=1 in the first cycle after reset.
- **Reset mid-operation.** All in-flight transfers are discarded. No partial result appears after rst deasserts. rst has priority over every load.
- **Latency.** A transfer accepted at edge t appears on out_valid/out_data after edge t+LAT−1, i.e. visible during cycle t+LAT. This holds when no stall occurs.
- **Throughput.** One transfer per cycle while out_ready=1.
- **Full pipeline.** With every stage valid and out_ready=0, in_ready=0.
- **Simultaneous in and out.** A full pipeline with out_ready=1 accepts a new input in the same cycle.
- **Bubble absorption.** If the pipeline is stalled but some stage is empty, upstream stages advance into the empty slot.

## Configuration
- MUXN_PIPE_ERR_EN
  - **Defined.** out_err exists. An out-of-range select yields out_data=0 and out_err=1, aligned with the same result. In-range selects give out_err=0.
  - **Undefined.** No out_err port and no error state bits. An out-of-range select yields in_data[N-1], i.e. the select is clamped.

## Test plan
Default configuration is N=5, WIDTH=32, so LAT=3.
- **Reset and latency.** Drive in_data[i]=32'hA0+i with out_ready=1, then send in_sel=0..4 on consecutive cycles. Expect:
  - out_valid=0 and out_data=0 for 3 cycles;
  - then 32'hA0..32'hA4 on 5 consecutive cycles;
  - in_ready=1 throughout.
- **Backpressure.** Stream 8 transfers with out_ready toggling 1,0,0,1,... Expect:
  - in_ready=0 only when all 3 stages are valid and out_ready=0;
  - output sequence is identical to input order with no loss or duplication.
- **Out-of-range select.** Send in_sel=6.
  - With MUXN_PIPE_ERR_EN: out_data=0, out_err=1.
  - Without: out_data=in_data[4].
  - A following in_sel=2 transfer gives out_err=0.
- **Reset mid-stream.** Assert rst for one cycle with 3 transfers in flight. Expect:
  - out_valid=0 from the next cycle;
  - none of the 3 results ever appears;
  - a fresh transfer emerges 3 cycles after acceptance.
- **Degenerate sizes.** N=1: out_data = in_data[0] after 1 cycle for any in_sel. N=2: LAT=1, in_sel=1 returns in_data[1].
- **Bubble collapse.** Insert a one-cycle in_valid=0 gap while out_ready=0, then raise out_ready. Expect:
  - the gap is squeezed out;
  - results are output back-to-back.
